// File: rtl/imem_loader.sv
// imem_loader -- boot-time instruction memory loader.
//
// Consumes a byte stream: a 16-bit word count N (high byte first), then N
// 16-bit instruction words (each high byte first). Each completed word is
// written to instruction memory with a single-cycle registered strobe. The
// core is held in reset for the whole load and released only after the last
// write has landed. An oversize count rejects the image and keeps the core
// in reset until the next rst.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  byte stream handshake; in_data is the stream byte
//   mem_we          one-cycle write strobe per instruction word
//   mem_addr        word address (valid while mem_we)
//   mem_wdata       instruction word (valid while mem_we)
//   core_rst        core reset, high except once the image is loaded
//   done            image loaded, core released
//   err             image rejected
module imem_loader #(
    parameter int p_INST_NUM = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        LEN_HI, LEN_LO, DATA_HI, DATA_LO, DRAIN, DONE, ERR
    } state_t;

    state_t      state, state_n;
    logic [15:0] count;
    logic [15:0] idx;
    logic [7:0]  hi_byte;
    logic        acc;
    logic [15:0] len_n;

    assign in_ready = (state == LEN_HI) || (state == LEN_LO) ||
                      (state == DATA_HI) || (state == DATA_LO);
    assign acc      = in_valid && in_ready;
    assign len_n    = {count[15:8], in_data};

    always_comb begin
        state_n = state;
        case (state)
            LEN_HI:  if (acc) state_n = LEN_LO;
            LEN_LO:  if (acc) begin
                if (len_n == 16'd0)
                    state_n = DRAIN;
                else if ({1'b0, len_n} > 17'(p_INST_NUM))
                    state_n = ERR;
                else
                    state_n = DATA_HI;
            end
            DATA_HI: if (acc) state_n = DATA_LO;
            // 17-bit compare so the final-word test can never wrap
            DATA_LO: if (acc) begin
                if (({1'b0, idx} + 17'd1) == {1'b0, count})
                    state_n = DRAIN;
                else
                    state_n = DATA_HI;
            end
            // one cycle so the registered final write retires before release
            DRAIN:   state_n = DONE;
            DONE:    state_n = DONE;
            ERR:     state_n = ERR;
            default: state_n = LEN_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LEN_HI;
            count     <= '0;
            idx       <= '0;
            hi_byte   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            core_rst  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state    <= state_n;
            mem_we   <= 1'b0;
            // status flags follow the current state, so done rises one edge
            // after DONE is entered (two edges after the final byte)
            core_rst <= (state != DONE);
            done     <= (state == DONE);
            err      <= (state == ERR);
            if (acc) begin
                case (state)
                    LEN_HI:  count[15:8] <= in_data;
                    LEN_LO: begin
                        count[7:0] <= in_data;
                        idx        <= '0;
                    end
                    DATA_HI: hi_byte <= in_data;
                    DATA_LO: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= idx;
                        mem_wdata <= {hi_byte, in_data};
                        idx       <= idx + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
